// File: rtl/cdb_arbiter_pkg.sv
// Shared types and widths for the common data bus arbiter: source encoding,
// ROB index and datapath widths, and the packed queue entry layouts.
package cdb_arbiter_pkg;

    localparam int ROB_IDX_W = 4;
    localparam int XLEN      = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    localparam int ALU_ENTRY_W = ROB_IDX_W + XLEN + 1 + XLEN;
    localparam int LSB_ENTRY_W = ROB_IDX_W + XLEN;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob;
        logic [XLEN-1:0]      val;
        logic                 jump;
        logic [XLEN-1:0]      pc;
    } alu_entry_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob;
        logic [XLEN-1:0]      value;
    } lsb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result producers on one side, the broadcast bus and status flags on the other.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic                 rdy;
    logic                 rollback;
    logic                 alu_config;
    logic [ROB_IDX_W-1:0] alu_rob_entry;
    logic [XLEN-1:0]      alu_val;
    logic                 alu_need_jump;
    logic [XLEN-1:0]      alu_jump_pc;
    logic                 lsb_config;
    logic [ROB_IDX_W-1:0] lsb_rob_entry;
    logic [XLEN-1:0]      lsb_value;
    logic                 alu_full;
    logic                 lsb_full;
    logic                 cdb_config;
    logic                 cdb_src;
    logic [ROB_IDX_W-1:0] cdb_rob_entry;
    logic [XLEN-1:0]      cdb_value;
    logic                 cdb_need_jump;
    logic [XLEN-1:0]      cdb_jump_pc;
    logic                 err_overflow;

    modport master (
        output rdy, rollback,
        output alu_config, alu_rob_entry, alu_val, alu_need_jump, alu_jump_pc,
        output lsb_config, lsb_rob_entry, lsb_value,
        input  alu_full, lsb_full,
        input  cdb_config, cdb_src, cdb_rob_entry, cdb_value, cdb_need_jump, cdb_jump_pc,
        input  err_overflow
    );

    modport slave (
        input  rdy, rollback,
        input  alu_config, alu_rob_entry, alu_val, alu_need_jump, alu_jump_pc,
        input  lsb_config, lsb_rob_entry, lsb_value,
        output alu_full, lsb_full,
        output cdb_config, cdb_src, cdb_rob_entry, cdb_value, cdb_need_jump, cdb_jump_pc,
        output err_overflow
    );

endinterface

// File: rtl/cdb_fifo.sv
// Per-source result queue. Pushes into a full queue are dropped even when a
// pop happens on the same edge; clear empties the queue regardless of enable.
module cdb_fifo #(
    parameter  int WIDTH = 36,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_en & i_push & ~o_full;
    assign w_pop   = i_en & i_pop & (r_count != {CNT_W{1'b0}});

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage is never reset; nothing reads it while the count is zero.
    always_ff @(posedge clk) begin
        if (!i_clr && w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues ALU and LSB results and broadcasts at most
// one per cycle, alternating between sources under contention.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);

    localparam int CNT_W = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

    logic                 w_clr;
    logic                 w_en;
    alu_entry_t           w_alu_in;
    alu_entry_t           w_alu_head;
    lsb_entry_t           w_lsb_in;
    lsb_entry_t           w_lsb_head;
    logic [CNT_W-1:0]     w_alu_count;
    logic [CNT_W-1:0]     w_lsb_count;
    logic                 w_alu_full;
    logic                 w_lsb_full;
    logic                 w_alu_ne;
    logic                 w_lsb_ne;
    logic                 w_grant_any;
    src_e                 w_grant_src;
    logic                 w_alu_pop;
    logic                 w_lsb_pop;
    logic                 w_overflow;

    src_e                 r_last_grant;
    logic                 r_cdb_config;
    src_e                 r_cdb_src;
    logic [ROB_IDX_W-1:0] r_cdb_rob_entry;
    logic [XLEN-1:0]      r_cdb_value;
    logic                 r_cdb_need_jump;
    logic [XLEN-1:0]      r_cdb_jump_pc;
    logic                 r_err_overflow;

    // Rollback outranks rdy, so it clears the queues even while stalled.
    assign w_clr    = rst | bus.rollback;
    assign w_en     = bus.rdy;
    assign w_alu_in = {bus.alu_rob_entry, bus.alu_val, bus.alu_need_jump, bus.alu_jump_pc};
    assign w_lsb_in = {bus.lsb_rob_entry, bus.lsb_value};
    assign w_alu_ne = (w_alu_count != {CNT_W{1'b0}});
    assign w_lsb_ne = (w_lsb_count != {CNT_W{1'b0}});

    cdb_fifo #(.WIDTH(ALU_ENTRY_W), .DEPTH(DEPTH)) u_alu_fifo (
        .clk     (clk),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_push  (bus.alu_config),
        .i_pop   (w_alu_pop),
        .i_data  (w_alu_in),
        .o_head  (w_alu_head),
        .o_count (w_alu_count),
        .o_full  (w_alu_full)
    );

    cdb_fifo #(.WIDTH(LSB_ENTRY_W), .DEPTH(DEPTH)) u_lsb_fifo (
        .clk     (clk),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_push  (bus.lsb_config),
        .i_pop   (w_lsb_pop),
        .i_data  (w_lsb_in),
        .o_head  (w_lsb_head),
        .o_count (w_lsb_count),
        .o_full  (w_lsb_full)
    );

    // Grant selection from the pre-edge queue heads.
    always_comb begin
        w_grant_any = w_alu_ne | w_lsb_ne;
        w_grant_src = SRC_ALU;
        if (w_alu_ne && w_lsb_ne) begin
            w_grant_src = (r_last_grant == SRC_LSB) ? SRC_ALU : SRC_LSB;
        end else if (w_lsb_ne) begin
            w_grant_src = SRC_LSB;
        end else begin
            w_grant_src = SRC_ALU;
        end
        w_alu_pop  = w_grant_any & (w_grant_src == SRC_ALU);
        w_lsb_pop  = w_grant_any & (w_grant_src == SRC_LSB);
        w_overflow = (bus.alu_config & w_alu_full) | (bus.lsb_config & w_lsb_full);
    end

    // Broadcast registers, fairness pointer and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant    <= SRC_LSB;
            r_cdb_config    <= 1'b0;
            r_cdb_src       <= SRC_ALU;
            r_cdb_rob_entry <= {ROB_IDX_W{1'b0}};
            r_cdb_value     <= {XLEN{1'b0}};
            r_cdb_need_jump <= 1'b0;
            r_cdb_jump_pc   <= {XLEN{1'b0}};
            r_err_overflow  <= 1'b0;
        end else if (bus.rollback) begin
            r_cdb_config <= 1'b0;
            r_last_grant <= SRC_LSB;
        end else if (bus.rdy) begin
            if (w_overflow) r_err_overflow <= 1'b1;
            if (w_grant_any) begin
                r_cdb_config <= 1'b1;
                r_cdb_src    <= w_grant_src;
                r_last_grant <= w_grant_src;
                case (w_grant_src)
                    SRC_ALU: begin
                        r_cdb_rob_entry <= w_alu_head.rob;
                        r_cdb_value     <= w_alu_head.val;
                        r_cdb_need_jump <= w_alu_head.jump;
                        r_cdb_jump_pc   <= w_alu_head.pc;
                    end
                    SRC_LSB: begin
                        r_cdb_rob_entry <= w_lsb_head.rob;
                        r_cdb_value     <= w_lsb_head.value;
                        r_cdb_need_jump <= 1'b0;
                        r_cdb_jump_pc   <= {XLEN{1'b0}};
                    end
                    default: begin
                        r_cdb_config <= 1'b0;
                    end
                endcase
            end else begin
                r_cdb_config <= 1'b0;
            end
        end
    end

    assign bus.alu_full      = w_alu_full;
    assign bus.lsb_full      = w_lsb_full;
    assign bus.cdb_config    = r_cdb_config;
    assign bus.cdb_src       = r_cdb_src;
    assign bus.cdb_rob_entry = r_cdb_rob_entry;
    assign bus.cdb_value     = r_cdb_value;
    assign bus.cdb_need_jump = r_cdb_need_jump;
    assign bus.cdb_jump_pc   = r_cdb_jump_pc;
    assign bus.err_overflow  = r_err_overflow;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scenarios followed by random traffic, all checked against a
// queue-based reference model of the arbiter.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    cdb_arbiter_if bus();

    cdb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    alu_entry_t  m_alu_q[$];
    lsb_entry_t  m_lsb_q[$];
    bit          m_last_lsb;
    logic        e_cfg;
    logic        e_src;
    logic [3:0]  e_rob;
    logic [31:0] e_val;
    logic        e_jump;
    logic [31:0] e_pc;
    logic        e_err;

    // Advance the reference model by one clock edge using the current inputs.
    function automatic void model_edge();
        bit         a_full;
        bit         l_full;
        bit         a_ne;
        bit         l_ne;
        bit         take_lsb;
        alu_entry_t ah;
        lsb_entry_t lh;
        if (rst) begin
            m_alu_q.delete();
            m_lsb_q.delete();
            e_cfg = 1'b0; e_src = 1'b0; e_rob = 4'd0; e_val = 32'd0;
            e_jump = 1'b0; e_pc = 32'd0; e_err = 1'b0;
            m_last_lsb = 1'b1;
        end else if (bus.rollback) begin
            m_alu_q.delete();
            m_lsb_q.delete();
            e_cfg = 1'b0;
            m_last_lsb = 1'b1;
        end else if (bus.rdy) begin
            a_full = (m_alu_q.size() == DEPTH);
            l_full = (m_lsb_q.size() == DEPTH);
            a_ne   = (m_alu_q.size() != 0);
            l_ne   = (m_lsb_q.size() != 0);
            if (a_ne || l_ne) begin
                take_lsb = (a_ne && l_ne) ? !m_last_lsb : l_ne;
                if (take_lsb) begin
                    lh = m_lsb_q.pop_front();
                    e_src = 1'b1; e_rob = lh.rob; e_val = lh.value;
                    e_jump = 1'b0; e_pc = 32'd0;
                end else begin
                    ah = m_alu_q.pop_front();
                    e_src = 1'b0; e_rob = ah.rob; e_val = ah.val;
                    e_jump = ah.jump; e_pc = ah.pc;
                end
                e_cfg = 1'b1;
                m_last_lsb = take_lsb;
            end else begin
                e_cfg = 1'b0;
            end
            if (bus.alu_config) begin
                if (a_full) e_err = 1'b1;
                else m_alu_q.push_back({bus.alu_rob_entry, bus.alu_val, bus.alu_need_jump, bus.alu_jump_pc});
            end
            if (bus.lsb_config) begin
                if (l_full) e_err = 1'b1;
                else m_lsb_q.push_back({bus.lsb_rob_entry, bus.lsb_value});
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic compare_all();
        chk("cdb_config",    {31'd0, bus.cdb_config},    {31'd0, e_cfg});
        chk("cdb_src",       {31'd0, bus.cdb_src},       {31'd0, e_src});
        chk("cdb_rob_entry", {28'd0, bus.cdb_rob_entry}, {28'd0, e_rob});
        chk("cdb_value",     bus.cdb_value,              e_val);
        chk("cdb_need_jump", {31'd0, bus.cdb_need_jump}, {31'd0, e_jump});
        chk("cdb_jump_pc",   bus.cdb_jump_pc,            e_pc);
        chk("err_overflow",  {31'd0, bus.err_overflow},  {31'd0, e_err});
        chk("alu_full", {31'd0, bus.alu_full}, (m_alu_q.size() == DEPTH) ? 32'd1 : 32'd0);
        chk("lsb_full", {31'd0, bus.lsb_full}, (m_lsb_q.size() == DEPTH) ? 32'd1 : 32'd0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        rst = 1'b0;
        bus.rdy = 1'b1;
        bus.rollback = 1'b0;
        bus.alu_config = 1'b0;
        bus.lsb_config = 1'b0;
    endtask

    task automatic push_alu(input logic [3:0] rob, input logic [31:0] val,
                            input logic jump, input logic [31:0] pc);
        bus.alu_config = 1'b1;
        bus.alu_rob_entry = rob;
        bus.alu_val = val;
        bus.alu_need_jump = jump;
        bus.alu_jump_pc = pc;
    endtask

    task automatic push_lsb(input logic [3:0] rob, input logic [31:0] val);
        bus.lsb_config = 1'b1;
        bus.lsb_rob_entry = rob;
        bus.lsb_value = val;
    endtask

    initial begin
        bit          seen_full;
        logic        prev_src;
        logic [31:0] rnd;

        idle();
        bus.alu_rob_entry = 4'd0; bus.alu_val = 32'd0;
        bus.alu_need_jump = 1'b0; bus.alu_jump_pc = 32'd0;
        bus.lsb_rob_entry = 4'd0; bus.lsb_value = 32'd0;
        rst = 1'b1;
        step();
        chk("reset_cfg", {31'd0, bus.cdb_config}, 32'd0);
        chk("reset_val", bus.cdb_value, 32'd0);

        // ALU only: push on edge 1, broadcast on edge 2, idle on edge 3
        idle();
        push_alu(4'd3, 32'h11, 1'b0, 32'd0);
        step();
        idle();
        step();
        chk("alu_only_cfg", {31'd0, bus.cdb_config}, 32'd1);
        chk("alu_only_src", {31'd0, bus.cdb_src}, 32'd0);
        chk("alu_only_rob", {28'd0, bus.cdb_rob_entry}, 32'd3);
        chk("alu_only_val", bus.cdb_value, 32'h11);
        step();
        chk("alu_only_drop", {31'd0, bus.cdb_config}, 32'd0);

        // Contention with last_grant=LSB: ALU first, then LSB with jump fields cleared
        bus.rollback = 1'b1;
        step();
        idle();
        push_alu(4'd1, 32'hAAAA, 1'b1, 32'h1234);
        push_lsb(4'd2, 32'hBBBB);
        step();
        idle();
        step();
        chk("cont_first_src", {31'd0, bus.cdb_src}, 32'd0);
        chk("cont_first_rob", {28'd0, bus.cdb_rob_entry}, 32'd1);
        chk("cont_first_jump", {31'd0, bus.cdb_need_jump}, 32'd1);
        step();
        chk("cont_second_src", {31'd0, bus.cdb_src}, 32'd1);
        chk("cont_second_rob", {28'd0, bus.cdb_rob_entry}, 32'd2);
        chk("cont_second_jump", {31'd0, bus.cdb_need_jump}, 32'd0);
        chk("cont_second_pc", bus.cdb_jump_pc, 32'd0);

        // Fairness: both sources fed every edge while their queues have room
        bus.rollback = 1'b1;
        step();
        seen_full = 1'b0;
        prev_src = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (m_alu_q.size() < DEPTH) push_alu(4'(i), $urandom, 1'b1, $urandom);
            if (m_lsb_q.size() < DEPTH) push_lsb(4'(i + 8), $urandom);
            step();
            if (bus.alu_full || bus.lsb_full) seen_full = 1'b1;
            if (i >= 2) chk("fair_alternate", {31'd0, bus.cdb_src}, {31'd0, ~prev_src});
            prev_src = bus.cdb_src;
        end
        chk("fair_full_seen", {31'd0, seen_full}, 32'd1);
        chk("fair_no_ovf", {31'd0, bus.err_overflow}, 32'd0);

        // Overflow: push both sources every edge ignoring the full flags
        bus.rollback = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            idle();
            push_alu(4'(i), 32'h100 + 32'(i), 1'b0, 32'd0);
            push_lsb(4'(i), 32'h200 + 32'(i));
            step();
        end
        chk("ovf_set", {31'd0, bus.err_overflow}, 32'd1);
        idle();
        step();
        bus.rollback = 1'b1;
        step();
        chk("ovf_sticky", {31'd0, bus.err_overflow}, 32'd1);

        // Rollback with same-edge LSB push: everything discarded
        idle();
        rst = 1'b1;
        step();
        idle(); push_alu(4'd4, 32'h44, 1'b0, 32'd0); push_lsb(4'd5, 32'h55); step();
        idle(); push_alu(4'd6, 32'h66, 1'b0, 32'd0); step();
        idle(); push_alu(4'd7, 32'h77, 1'b0, 32'd0); push_lsb(4'd8, 32'h88); step();
        idle();
        bus.rollback = 1'b1;
        push_lsb(4'd9, 32'h99);
        step();
        chk("rb_cfg", {31'd0, bus.cdb_config}, 32'd0);
        chk("rb_alu_empty", {31'd0, bus.alu_full}, 32'd0);
        idle();
        step();
        chk("rb_no_grant1", {31'd0, bus.cdb_config}, 32'd0);
        step();
        chk("rb_no_grant2", {31'd0, bus.cdb_config}, 32'd0);

        // Stall: rdy low for 3 edges freezes everything despite input activity
        idle(); push_alu(4'd10, 32'hA0, 1'b0, 32'd0); push_lsb(4'd11, 32'hB0); step();
        idle(); step();
        for (int i = 0; i < 3; i++) begin
            idle();
            bus.rdy = 1'b0;
            push_alu(4'(i), $urandom, 1'b1, $urandom);
            push_lsb(4'(i), $urandom);
            step();
            chk("stall_cfg", {31'd0, bus.cdb_config}, 32'd1);
            chk("stall_rob", {28'd0, bus.cdb_rob_entry}, 32'd10);
        end
        idle();
        step();
        chk("stall_resume_src", {31'd0, bus.cdb_src}, 32'd1);
        chk("stall_resume_rob", {28'd0, bus.cdb_rob_entry}, 32'd11);

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            idle();
            rnd = $urandom;
            rst = (rnd[7:0] == 8'd0);
            bus.rollback = (rnd[12:8] == 5'd0);
            bus.rdy = (rnd[15:13] != 3'd0);
            if (rnd[16] && (m_alu_q.size() < DEPTH || rnd[23:20] == 4'd0))
                push_alu(4'($urandom), $urandom, 1'($urandom), $urandom);
            if (rnd[17] && (m_lsb_q.size() < DEPTH || rnd[27:24] == 4'd0))
                push_lsb(4'($urandom), $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
